// File: rtl/csr_counter_bank.sv
// Performance-counter CSR bank: writable mcycle/minstret/mhpmcounters, mcountinhibit,
// a prescaled read-only time base, and user-level read-only aliases.
module csr_counter_bank #(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_HPM   = 4,
    parameter int TIME_DIV  = 1,
    parameter int RETIRE_W  = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_ni,
    input  logic [11:0]                            sel_i,
    input  logic [31:0]                            din_i,
    input  logic                                   we_i,
    input  logic [RETIRE_W-1:0]                    instret_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic [31:0]                            dout_o,
    output logic                                   illegal_o
);
    localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int PS_W  = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
    localparam logic [31:0] INH_MASK = 32'h0000_0005 | HPM_BITS[31:0];

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    cnt_t            mcycle_q;
    cnt_t            minstret_q;
    cnt_t            time_q;
    cnt_t            hpm_q [HPM_W];
    logic [31:0]     inhibit_q;
    logic [PS_W-1:0] ps_q;
    logic            tick;

    // Address decode: the low 5 bits pick the counter, bits [11:5] pick the bank.
    logic [4:0] idx;
    logic       m_lo, m_hi, u_lo, u_hi, is_inh, ro_space, mapped, hi_half;

    assign idx       = sel_i[4:0];
    assign m_lo      = (sel_i[11:5] == 7'h58) && (idx != 5'd1);
    assign m_hi      = (sel_i[11:5] == 7'h5C) && (idx != 5'd1);
    assign u_lo      = (sel_i[11:5] == 7'h60);
    assign u_hi      = (sel_i[11:5] == 7'h64);
    assign is_inh    = (sel_i == 12'h320);
    assign ro_space  = (sel_i >= 12'hC00) && (sel_i <= 12'hC9F);
    assign mapped    = m_lo || m_hi || u_lo || u_hi || is_inh;
    assign hi_half   = m_hi || u_hi;
    assign illegal_o = !mapped || (we_i && ro_space);

    cnt_t        rd_cnt;
    logic [63:0] rd_ext;

    always_comb begin
        rd_cnt = '0;
        case (idx)
            5'd0:    rd_cnt = mcycle_q;
            5'd1:    rd_cnt = time_q;
            5'd2:    rd_cnt = minstret_q;
            default: begin
                for (int k = 0; k < NUM_HPM; k++) begin
                    if (idx == 5'(k + 3)) rd_cnt = hpm_q[k];
                end
            end
        endcase
    end

    assign rd_ext = 64'(rd_cnt);

    always_comb begin
        dout_o = '0;
        if (is_inh) begin
            dout_o = inhibit_q;
        end else if (mapped) begin
            dout_o = hi_half ? rd_ext[63:32] : rd_ext[31:0];
        end
    end

    logic wr_lo, wr_hi, wr_inh, wr_cyc, wr_ret;

    assign wr_lo  = we_i && m_lo;
    assign wr_hi  = we_i && m_hi;
    assign wr_inh = we_i && is_inh;
    assign wr_cyc = (wr_lo || wr_hi) && (idx == 5'd0);
    assign wr_ret = (wr_lo || wr_hi) && (idx == 5'd2);

    // Replace one 32-bit half; bits above CNT_WIDTH fall off in the truncation.
    function automatic cnt_t merge(input cnt_t old, input logic lo, input logic hi,
                                   input logic [31:0] d);
        logic [63:0] ext;
        ext = 64'(old);
        if (lo) ext[31:0] = d;
        if (hi) ext[63:32] = d;
        return ext[CNT_WIDTH-1:0];
    endfunction

    assign tick = (ps_q == PS_W'(TIME_DIV - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            time_q     <= '0;
            ps_q       <= '0;
            inhibit_q  <= '0;
        end else begin
            ps_q <= tick ? '0 : ps_q + PS_W'(1);
            if (tick) time_q <= time_q + CNT_WIDTH'(1);

            if (wr_cyc) mcycle_q <= merge(mcycle_q, wr_lo, wr_hi, din_i);
            else if (!inhibit_q[0]) mcycle_q <= mcycle_q + CNT_WIDTH'(1);

            if (wr_ret) minstret_q <= merge(minstret_q, wr_lo, wr_hi, din_i);
            else if (!inhibit_q[2]) minstret_q <= minstret_q + CNT_WIDTH'(instret_i);

            if (wr_inh) inhibit_q <= din_i & INH_MASK;
        end
    end

    for (genvar k = 0; k < NUM_HPM; k++) begin : g_hpm
        logic wr_k;
        assign wr_k = (wr_lo || wr_hi) && (idx == 5'(k + 3));

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                hpm_q[k] <= '0;
            end else if (wr_k) begin
                hpm_q[k] <= merge(hpm_q[k], wr_lo, wr_hi, din_i);
            end else if (hpm_event_i[k] && !inhibit_q[3+k]) begin
                hpm_q[k] <= hpm_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    if (NUM_HPM == 0) begin : g_no_hpm
        assign hpm_q[0] = '0;
    end

endmodule
